// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile transposer.
//   N_DEF / W_DEF : default tile dimension and element width
//   elem_t        : one element
//   vec_t         : one row or one column (N elements)
//   tile_t        : one full N x N tile
//   clog2_min1    : counter width helper that never returns zero
package tile_pkg;

  localparam int N_DEF = 10;
  localparam int W_DEF = 10;

  typedef logic [W_DEF-1:0] elem_t;
  typedef elem_t [N_DEF-1:0] vec_t;
  typedef vec_t  [N_DEF-1:0] tile_t;

  // Width of a counter that must hold 0..n-1; a one-bit minimum keeps
  // degenerate sizes from producing zero-width vectors.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/tile_bank_ctrl.sv
// Bank pointer and beat counter for one side of the transposer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_adv          : a beat was accepted on this side this cycle
//   o_bank         : bank currently being filled (write) or drained (read)
//   o_cnt          : beat index within the current tile, 0..N-1
//   o_last         : o_cnt is on the final beat of the tile
// On an accepted final beat the counter wraps to zero and the bank flips.
module tile_bank_ctrl
  import tile_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = clog2_min1(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_adv,
  output logic          o_bank,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  assign o_last = (o_cnt == CW'(N - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bank <= 1'b0;
      o_cnt  <= '0;
    end else if (i_adv) begin
      if (o_last) begin
        o_cnt  <= '0;
        o_bank <= ~o_bank;
      end else begin
        o_cnt <= o_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tile_transposer.sv
// Ping-pong N x N tile transposer.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_valid/o_ready : row handshake; i_row[j] is column j of the row
//   i_last          : producer end-of-tile marker, only cross-checked
//   o_valid/i_ready : column handshake; o_col[i] is row i of the column
//   o_last          : final column of a tile
//   o_err           : sticky, i_last disagreed with the row count
// Two banks: one fills row by row while the other drains column by column.
module tile_transposer
  import tile_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N-1:0][W-1:0]   i_row,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N-1:0][W-1:0]   o_col,
  output logic                  o_last,
  output logic                  o_err
);

  localparam int CW = clog2_min1(N);

  logic [N-1:0][N-1:0][W-1:0] mem [2];
  logic [1:0]                 bank_full;

  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_row, rd_col;
  logic          wr_last, rd_last;
  logic          wr_fire, rd_fire;

  // A bank is writable only while empty and readable only while full, so
  // the two sides can never touch the same bank in one cycle.
  assign o_ready = !bank_full[wr_bank];
  assign wr_fire = i_valid && o_ready;
  assign o_valid = bank_full[rd_bank];
  assign rd_fire = o_valid && i_ready;
  assign o_last  = o_valid && rd_last;

  tile_bank_ctrl #(.N(N), .CW(CW)) u_wr_ctrl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (wr_fire),
    .o_bank  (wr_bank),
    .o_cnt   (wr_row),
    .o_last  (wr_last)
  );

  tile_bank_ctrl #(.N(N), .CW(CW)) u_rd_ctrl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (rd_fire),
    .o_bank  (rd_bank),
    .o_cnt   (rd_col),
    .o_last  (rd_last)
  );

  // NOTE: tile storage is deliberately left out of reset; bank_full gates
  // every read, so stale contents are never presented as valid.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_row] <= i_row;
    end
  end

  // Column select: element i of the output is row i at the current column.
  // NOTE: the output gets a full default before the loop so no path through
  // this block can leave it unassigned and infer a latch.
  always_comb begin
    o_col = '0;
    for (int i = 0; i < N; i++) begin
      o_col[i] = mem[rd_bank][i][rd_col];
    end
  end

  // Fill-complete and drain-complete may land together; they always
  // address different banks, so both updates take effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_full <= '0;
    end else begin
      if (wr_fire && wr_last) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (rd_fire && rd_last) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // The producer's marker is only audited; control relies on wr_row alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (wr_fire && (i_last != wr_last)) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_transposer.sv
// Self-checking bench for tile_transposer. A tile-level reference model
// (tile queue, stored-tile count) predicts every handshake and column.
module tb_tile_transposer;
  import tile_pkg::*;

  localparam int N = N_DEF;
  localparam int W = W_DEF;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_valid, o_ready, i_last, o_valid, i_ready, o_last, o_err;
  vec_t i_row, o_col;

  tile_transposer #(.N(N), .W(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_row   (i_row),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_col   (o_col),
    .o_last  (o_last),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_stored;      // complete tiles held and not yet fully drained
  int   m_rows;        // rows accepted into the tile being filled
  bit   m_err;
  int   m_lasts;
  int   m_cols;
  int   m_wr_count;
  vec_t m_tile [N];
  vec_t exp_q[$];
  bit   exp_last_q[$];
  bit   prev_stall;
  vec_t prev_col;
  bit   saw_not_ready;
  // DUT values seen at the most recent sample point
  bit   s_valid, s_last;
  vec_t s_col;

  task automatic model_reset();
    m_stored = 0; m_rows = 0; m_err = 0;
    exp_q.delete(); exp_last_q.delete();
    prev_stall = 0;
  endtask

  task automatic model_step();
    bit   er, ev;
    vec_t col;
    er = (m_stored < 2);
    ev = (m_stored > 0);
    s_valid = o_valid; s_col = o_col; s_last = o_last;
    check("o_ready", o_ready, er);
    check("o_valid", o_valid, ev);
    check("o_err", o_err, m_err);
    if (!o_ready) saw_not_ready = 1;
    if (ev) begin
      check("o_col", o_col, exp_q[0]);
      check("o_last", o_last, exp_last_q[0]);
    end else begin
      check("o_last_idle", o_last, 1'b0);
    end
    if (prev_stall && o_valid) check("stall_hold", o_col, prev_col);
    prev_stall = o_valid && !i_ready;
    prev_col   = o_col;
    if (ev && i_ready) begin
      if (exp_last_q[0]) begin
        m_stored--;
        m_lasts++;
      end
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
      m_cols++;
    end
    if (i_valid && er) begin
      if (i_last != (m_rows == N - 1)) m_err = 1;
      m_tile[m_rows] = i_row;
      m_rows++;
      m_wr_count++;
      if (m_rows == N) begin
        for (int c = 0; c < N; c++) begin
          for (int i = 0; i < N; i++) col[i] = m_tile[i][c];
          exp_q.push_back(col);
          exp_last_q.push_back(c == N - 1);
        end
        m_stored++;
        m_rows = 0;
      end
    end
  endtask

  // One clock: drive after the rising edge, sample on the falling edge.
  task automatic cyc(input bit v, input vec_t row, input bit lst, input bit rdy);
    i_valid = v; i_row = row; i_last = lst; i_ready = rdy;
    @(negedge i_clk);
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk_row(input int t, input int r);
    vec_t v;
    for (int j = 0; j < N; j++) v[j] = W'((t << 8) | (r << 4) | j);
    return v;
  endfunction

  function automatic vec_t rnd_row();
    vec_t v;
    for (int j = 0; j < N; j++) v[j] = W'($urandom);
    return v;
  endfunction

  task automatic drain(input int r_pct);
    int b;
    b = 3000;
    while (m_stored > 0 && b > 0) begin
      cyc(0, rnd_row(), 0, $urandom_range(99) < r_pct);
      b--;
    end
  endtask

  typedef struct {
    int n_tiles;
    int v_pct;
    int r_pct;
    int exp_lasts;
  } scen_t;

  scen_t scen [3];

  initial begin
    int base, sent, budget, pre;
    vec_t row;

    scen[0] = '{n_tiles: 8, v_pct: 50,  r_pct: 50,  exp_lasts: 8};
    scen[1] = '{n_tiles: 3, v_pct: 100, r_pct: 30,  exp_lasts: 3};
    scen[2] = '{n_tiles: 3, v_pct: 30,  r_pct: 100, exp_lasts: 3};

    m_lasts = 0; m_cols = 0; m_wr_count = 0; saw_not_ready = 0;
    model_reset();
    i_valid = 0; i_ready = 0; i_last = 0; i_row = '0;
    i_rst_n = 0;
    #12;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_ready", o_ready, 1'b1);
    check("rst_o_last", o_last, 1'b0);
    check("rst_o_err", o_err, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1;

    // ---- single tile, r*16+j, consumer always ready ----
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) row[j] = W'(r * 16 + j);
      cyc(1, row, r == N - 1, 1);
      check("no_early_valid", s_valid, 1'b0);
    end
    for (int c = 0; c < N; c++) begin
      cyc(0, '0, 0, 1);
      check("tile0_valid", s_valid, 1'b1);
      for (int i = 0; i < N; i++) check("tile0_elem", s_col[i], W'(i * 16 + c));
      check("tile0_last", s_last, c == N - 1);
    end
    cyc(0, '0, 0, 1);
    check("tile0_done", s_valid, 1'b0);
    check("tile0_err", o_err, 1'b0);

    // ---- four tiles back to back ----
    saw_not_ready = 0;
    base = m_cols;
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < N; r++) cyc(1, mk_row(t, r), r == N - 1, 1);
    drain(100);
    check("b2b_ready_held", saw_not_ready, 1'b0);
    check("b2b_cols", m_cols - base, 4 * N);

    // ---- consumer blocked until both banks are full ----
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < N; r++) cyc(1, mk_row(t + 4, r), r == N - 1, 0);
    pre = m_wr_count;
    for (int k = 0; k < 3; k++) cyc(1, mk_row(15, k), 0, 0);
    check("full_dropped", m_wr_count - pre, 0);
    check("full_not_ready", o_ready, 1'b0);
    drain(100);

    // ---- randomized scenarios from the table ----
    foreach (scen[s]) begin
      base = m_lasts;
      sent = 0;
      budget = 6000;
      while (sent < scen[s].n_tiles * N && budget > 0) begin
        pre = m_wr_count;
        cyc($urandom_range(99) < scen[s].v_pct, rnd_row(), m_rows == N - 1,
            $urandom_range(99) < scen[s].r_pct);
        if (m_wr_count > pre) sent++;
        budget--;
      end
      drain(scen[s].r_pct);
      check("scen_lasts", m_lasts - base, scen[s].exp_lasts);
      check("scen_empty", exp_q.size(), 0);
    end

    // ---- i_last on row 3 ----
    for (int r = 0; r < N; r++) begin
      cyc(1, mk_row(2, r), (r == 3) || (r == N - 1), 1);
      if (r == 4) check("err_set", o_err, 1'b1);
    end
    drain(100);
    check("err_sticky", o_err, 1'b1);

    // ---- reset after 5 rows ----
    for (int r = 0; r < 5; r++) cyc(1, mk_row(3, r), 0, 1);
    i_valid = 0;
    #2;
    i_rst_n = 0;
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_err", o_err, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    model_reset();
    #1;
    check("post_rst_valid", o_valid, 1'b0);
    check("post_rst_ready", o_ready, 1'b1);
    check("post_rst_err", o_err, 1'b0);
    for (int r = 0; r < N; r++) cyc(1, mk_row(1, r), r == N - 1, 0);
    for (int c = 0; c < N; c++) begin
      cyc(0, '0, 0, 1);
      for (int i = 0; i < N; i++) check("post_rst_elem", s_col[i], W'((1 << 8) | (i << 4) | c));
    end
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_transposer.md
Name: tile_transposer

Overview:
- Ping-pong matrix transposer between a row-producing stage and a column-consuming stage.
- Accepts an N x N tile of W-bit elements one row per beat; after the full tile is stored, emits it one column per beat.
- Two tile banks are held in a two-entry array, so tile k+1 can be filled while tile k drains.
- Both sides use valid/ready handshakes.

Parameters:
- N, 10, tile dimension: elements per row and per column, and beats per tile; N >= 2.
- W, 10, element width in bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input row present.
- o_ready  output  1  transposer can accept a row.
- i_row  input  N*W  packed [N-1:0][W-1:0]; element j is column j of the current row.
- i_last  input  1  producer's end-of-tile marker; checked only, never used for control.
- o_valid  output  1  output column present.
- i_ready  input  1  consumer accepts the column.
- o_col  output  N*W  packed [N-1:0][W-1:0]; element i is row i of the current column.
- o_last  output  1  high on the final column (index N-1) of a tile.
- o_err  output  1  sticky; set when i_last disagrees with the internal row count on an accepted beat.

Behaviour:
- Storage:
  - mem[0:1] of packed [N-1:0][N-1:0][W-1:0].
  - bank_full[0:1] flags.
  - wr_bank, rd_bank: 1 bit each.
  - wr_row, rd_col: counters of width max(1, clog2(N)).
- Reset (async, i_rst_n low): bank_full = 0, wr_bank = 0, rd_bank = 0, wr_row = 0, rd_col = 0, o_err = 0. Therefore o_valid = 0, o_ready = 1, o_last = 0. mem is not reset; o_col is don't-care while o_valid = 0.
- Write side:
  - o_ready = !bank_full[wr_bank] (combinational from state only; it never depends on i_valid).
  - Accepted beat = i_valid and o_ready: mem[wr_bank][wr_row] <= i_row.
  - If wr_row == N-1: wr_row <= 0, bank_full[wr_bank] <= 1, wr_bank flips. Otherwise wr_row increments.
- Read side:
  - o_valid = bank_full[rd_bank].
  - o_col[i] = mem[rd_bank][i][rd_col] (combinational select from registers).
  - o_last = o_valid and (rd_col == N-1).
  - Accepted beat = o_valid and i_ready. If rd_col == N-1: rd_col <= 0, bank_full[rd_bank] <= 0, rd_bank flips. Otherwise rd_col increments.
- Latency: o_valid rises the cycle after the row N-1 handshake. Minimum tile latency is N cycles from the first row to the first column.
- Throughput: one beat per cycle on each side in steady state. Continuous streaming with i_ready held high never deasserts o_ready.
- Simultaneous events:
  - A fill-complete and a drain-complete in the same cycle touch different banks. Both flag updates apply.
  - A bank freed by the drain may be written from the next cycle on.
  - A single bank is never written and read in the same cycle: writes require !full, reads require full.
- Both banks full: o_ready = 0. i_row is ignored regardless of i_valid.
- Stall: while i_ready = 0, o_col, o_last and rd_col hold stable.
- i_last check: on an accepted write, if i_last != (wr_row == N-1), then o_err <= 1. Control flow is unaffected. o_err clears only on reset.
- Reset mid-tile: partial tiles are discarded, counters return to zero, and the next accepted row is row 0 of bank 0.

Decomposition:
- Shared package tile_pkg holds:
  - localparams for the default N and W;
  - typedef elem_t (logic [W-1:0]);
  - typedef vec_t (elem_t [N-1:0]);
  - typedef tile_t (vec_t [N-1:0]);
  - function clog2_min1.
- One natural sub-module: tile_bank_ctrl. It is instantiated once per side and holds the pointer bank, the beat counter, and the wrap/flip logic with a "last" output.
- The bank_full flags and mem stay in tile_transposer.

Test Plan:
- Single tile, N=10, W=10, i_row[r][j] = r*16+j, consumer always ready:
  - o_valid rises exactly 1 cycle after the 10th write.
  - Column c gives o_col[i] = i*16+c.
  - o_last high only on c = 9.
  - o_err = 0.
- Back-to-back 4 tiles, i_ready = 1: o_ready stays 1 throughout, 40 columns come out in order, and the tile index is encoded in the upper bits of each element.
- i_ready = 0 until 2 tiles are written:
  - o_ready = 0 after the 20th row.
  - Extra i_valid beats are dropped, with contents unchanged.
  - Releasing i_ready drains tile 0, then tile 1. o_ready returns to 1 the cycle after column 9 of tile 0 is accepted.
- Random i_valid/i_ready (50%) for 8 tiles: the scoreboard matches the transpose of every tile, o_col is stable during stalls, and o_last count = 8.
- i_last asserted on row 3 of a tile: o_err = 1 from the next cycle, the tile still completes after 10 rows, and output data is correct.
- Assert i_rst_n low after 5 rows, then release:
  - o_valid = 0 and o_ready = 1 during and after reset.
  - o_err = 0.
  - A fresh 10-row tile transposes correctly out of bank 0.
